// File: rtl/vga_pixel_gen.sv
// Pixel stage behind the VGA timing generator. It draws a border, a background
// and a bouncing square. Colour and sync leave through matched one-cycle registers.
module vga_pixel_gen #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int BOX_SIZE = 32,
  parameter int STEP     = 2,
  parameter int BORDER   = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       active_video,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       pause,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       frame_tick
);

  localparam logic [10:0] X_MIN     = 11'(BORDER);
  localparam logic [10:0] X_MAX     = 11'(H_ACTIVE - BORDER - BOX_SIZE);
  localparam logic [10:0] Y_MIN     = 11'(BORDER);
  localparam logic [10:0] Y_MAX     = 11'(V_ACTIVE - BORDER - BOX_SIZE);
  localparam logic [10:0] H_EDGE    = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] V_EDGE    = 11'(V_ACTIVE - BORDER);
  localparam logic [10:0] BORDER_W  = 11'(BORDER);
  localparam logic [10:0] BOX_W     = 11'(BOX_SIZE);
  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [9:0]  STEP_P    = 10'(STEP);
  localparam logic [9:0]  RESET_POS = 10'(BORDER);
  localparam logic [11:0] BG_RGB    = 12'h004;
  localparam logic [11:0] BORDER_RGB = 12'hFFF;

  typedef struct packed {
    logic [9:0] pos;
    logic       dir;
    logic       bounce;
  } axis_t;

  // One axis of motion. The arithmetic is 11 bits wide so that pos+STEP cannot wrap before the limit compare.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input logic        dir,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
    axis_t       res;
    logic [10:0] pos_w;
    logic [10:0] sum_w;
    pos_w      = {1'b0, pos};
    sum_w      = pos_w + STEP_W;
    res.pos    = pos;
    res.dir    = dir;
    res.bounce = 1'b0;
    if (dir && (sum_w >= hi)) begin
      res.pos    = hi[9:0];
      res.dir    = 1'b0;
      res.bounce = 1'b1;
    end else if (!dir && (pos_w <= (lo + STEP_W))) begin
      res.pos    = lo[9:0];
      res.dir    = 1'b1;
      res.bounce = 1'b1;
    end else if (dir) begin
      res.pos = sum_w[9:0];
    end else begin
      res.pos = pos - STEP_P;
    end
    return res;
  endfunction

  function automatic logic [11:0] palette(input logic [2:0] idx);
    logic [11:0] rgb;
    case (idx)
      3'd0:    rgb = 12'hF00;
      3'd1:    rgb = 12'h0F0;
      3'd2:    rgb = 12'h00F;
      3'd3:    rgb = 12'hFF0;
      3'd4:    rgb = 12'h0FF;
      3'd5:    rgb = 12'hF0F;
      3'd6:    rgb = 12'hF80;
      3'd7:    rgb = 12'hFFF;
      default: rgb = 12'h000;
    endcase
    return rgb;
  endfunction

  logic        vs_prev_r;
  logic [9:0]  box_x_r;
  logic [9:0]  box_y_r;
  logic        dx_r;
  logic        dy_r;
  logic [2:0]  color_idx_r;
  logic [11:0] rgb_r;
  logic        hsync_r;
  logic        vsync_r;
  logic        frame_tick_r;

  logic        frame_edge_s;
  axis_t       step_x_s;
  axis_t       step_y_s;
  logic [9:0]  box_x_nxt_s;
  logic [9:0]  box_y_nxt_s;
  logic        dx_nxt_s;
  logic        dy_nxt_s;
  logic [2:0]  color_nxt_s;
  logic [10:0] x_w_s;
  logic [10:0] y_w_s;
  logic        in_border_s;
  logic        in_box_s;
  logic [11:0] rgb_s;

  assign frame_edge_s = vs_prev_r & ~vsync_in;

  // Motion update: advance once per frame edge unless paused; a bounce on either axis bumps the colour once.
  always_comb begin
    step_x_s    = axis_step(box_x_r, dx_r, X_MIN, X_MAX);
    step_y_s    = axis_step(box_y_r, dy_r, Y_MIN, Y_MAX);
    box_x_nxt_s = box_x_r;
    box_y_nxt_s = box_y_r;
    dx_nxt_s    = dx_r;
    dy_nxt_s    = dy_r;
    color_nxt_s = color_idx_r;
    if (frame_edge_s && !pause) begin
      box_x_nxt_s = step_x_s.pos;
      box_y_nxt_s = step_y_s.pos;
      dx_nxt_s    = step_x_s.dir;
      dy_nxt_s    = step_y_s.dir;
      color_nxt_s = color_idx_r + {2'b00, (step_x_s.bounce | step_y_s.bounce)};
    end else begin
      box_x_nxt_s = box_x_r;
      box_y_nxt_s = box_y_r;
      dx_nxt_s    = dx_r;
      dy_nxt_s    = dy_r;
      color_nxt_s = color_idx_r;
    end
  end

  // Pixel colour by priority: blanking, border, square, background.
  always_comb begin
    x_w_s       = {1'b0, x};
    y_w_s       = {1'b0, y};
    in_border_s = (x_w_s < BORDER_W) || (x_w_s >= H_EDGE) ||
                  (y_w_s < BORDER_W) || (y_w_s >= V_EDGE);
    in_box_s    = (x_w_s >= {1'b0, box_x_r}) && (x_w_s < ({1'b0, box_x_r} + BOX_W)) &&
                  (y_w_s >= {1'b0, box_y_r}) && (y_w_s < ({1'b0, box_y_r} + BOX_W));
    rgb_s       = 12'h000;
    if (!active_video) begin
      rgb_s = 12'h000;
    end else if (in_border_s) begin
      rgb_s = BORDER_RGB;
    end else if (in_box_s) begin
      rgb_s = palette(color_idx_r);
    end else begin
      rgb_s = BG_RGB;
    end
  end

  // Motion state and frame-edge detector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_prev_r   <= 1'b1;
      box_x_r     <= RESET_POS;
      box_y_r     <= RESET_POS;
      dx_r        <= 1'b1;
      dy_r        <= 1'b1;
      color_idx_r <= 3'd0;
    end else begin
      vs_prev_r   <= vsync_in;
      box_x_r     <= box_x_nxt_s;
      box_y_r     <= box_y_nxt_s;
      dx_r        <= dx_nxt_s;
      dy_r        <= dy_nxt_s;
      color_idx_r <= color_nxt_s;
    end
  end

  // Output registers keep colour, sync and tick on the same one-cycle latency.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rgb_r        <= 12'h000;
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      rgb_r        <= rgb_s;
      hsync_r      <= hsync_in;
      vsync_r      <= vsync_in;
      frame_tick_r <= frame_edge_s;
    end
  end

  assign red        = rgb_r[11:8];
  assign green      = rgb_r[7:4];
  assign blue       = rgb_r[3:0];
  assign hsync_out  = hsync_r;
  assign vsync_out  = vsync_r;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_pixel_gen.sv
// Directed bench for vga_pixel_gen: reset, rendering, bounce sequence, pause,
// simultaneous bounce (small-screen instance) and sync/colour alignment.
module tb_vga_pixel_gen;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rst2_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       active_video;
  logic       hsync_in;
  logic       vsync_in;
  logic       pause;
  logic       hsync_out, vsync_out, frame_tick;
  logic [3:0] red, green, blue;
  logic       hsync_out2, vsync_out2, frame_tick2;
  logic [3:0] red2, green2, blue2;

  int n_vec = 0;
  int n_bad = 0;

  vga_pixel_gen dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .active_video(active_video),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .hsync_out(hsync_out), .vsync_out(vsync_out),
    .red(red), .green(green), .blue(blue), .frame_tick(frame_tick)
  );

  // Square 100x100 screen: both axes reach 64 on the same frame edge.
  vga_pixel_gen #(.H_ACTIVE(100), .V_ACTIVE(100)) dut2 (
    .clk(clk), .rst_n(rst2_n), .x(x), .y(y), .active_video(active_video),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .pause(pause),
    .hsync_out(hsync_out2), .vsync_out(vsync_out2),
    .red(red2), .green(green2), .blue(blue2), .frame_tick(frame_tick2)
  );

  always #20 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rgb1();
    return 32'({red, green, blue});
  endfunction

  task automatic frame_edge();
    vsync_in = 1'b0;
    cyc();
    chk_vec("tick_hi", 32'(frame_tick), 32'd1);
    vsync_in = 1'b1;
    cyc();
    chk_vec("tick_lo", 32'(frame_tick), 32'd0);
  endtask

  task automatic pix(input string tag, input int xv, input int yv, input logic [31:0] exp);
    x            = 10'(xv);
    y            = 10'(yv);
    active_video = 1'b1;
    cyc();
    chk_vec(tag, rgb1(), exp);
    active_video = 1'b0;
  endtask

  task automatic chk_box(input string tag, input int bx, input int by, input int ddx,
                         input int ddy, input int col);
    chk_vec({tag, "_bx"}, 32'(dut.box_x_r), 32'(bx));
    chk_vec({tag, "_by"}, 32'(dut.box_y_r), 32'(by));
    chk_vec({tag, "_dx"}, 32'(dut.dx_r), 32'(ddx));
    chk_vec({tag, "_dy"}, 32'(dut.dy_r), 32'(ddy));
    chk_vec({tag, "_col"}, 32'(dut.color_idx_r), 32'(col));
  endtask

  logic hs_v, vs_v, av_v;

  initial begin
    rst_n = 1'b0; rst2_n = 1'b0;
    x = 10'd0; y = 10'd0; active_video = 1'b0;
    hsync_in = 1'b1; vsync_in = 1'b1; pause = 1'b0;

    // Reset held low: a vsync fall must not produce a tick.
    cyc();
    vsync_in = 1'b0;
    cyc();
    chk_vec("rst_tick", 32'(frame_tick), 32'd0);
    chk_vec("rst_vs", 32'(vsync_out), 32'd1);
    vsync_in = 1'b1;
    cyc();
    rst_n = 1'b1;
    chk_vec("rst_rgb", rgb1(), 32'h000);
    chk_vec("rst_hs", 32'(hsync_out), 32'd1);
    chk_box("rst", 4, 4, 1, 1, 0);

    pix("bg0", 100, 100, 32'h004);
    pix("box_corner0", 4, 4, 32'hF00);

    // Single frame edge.
    frame_edge();
    chk_box("f1", 6, 6, 1, 1, 0);
    pix("f1_box", 10, 10, 32'hF00);
    pix("f1_border", 3, 100, 32'hFFF);
    pix("f1_bg", 100, 100, 32'h004);
    pix("f1_box_last", 37, 37, 32'hF00);
    pix("f1_box_past", 38, 37, 32'h004);
    pix("r_border_in", 635, 100, 32'h004);
    pix("r_border", 636, 100, 32'hFFF);
    pix("b_border_in", 100, 475, 32'h004);
    pix("b_border", 100, 476, 32'hFFF);
    x = 10'd10; y = 10'd10; active_video = 1'b0;
    cyc();
    chk_vec("blank", rgb1(), 32'h000);

    // Bottom bounce after 220 edges, right bounce after 300.
    repeat (219) frame_edge();
    chk_box("e220", 444, 444, 1, 0, 1);
    repeat (80) frame_edge();
    chk_box("e300", 604, 284, 0, 0, 2);
    pix("e300_box", 604, 284, 32'h00F);
    pix("e300_box_edge", 635, 315, 32'h00F);
    pix("e300_left", 603, 284, 32'h004);

    // Pause freezes motion but ticks keep coming.
    pause = 1'b1;
    repeat (5) frame_edge();
    chk_box("pause", 604, 284, 0, 0, 2);
    pause = 1'b0;
    frame_edge();
    chk_box("unpause", 602, 282, 0, 0, 2);

    // Simultaneous bounce on the square-screen instance.
    rst2_n = 1'b1;
    repeat (29) frame_edge();
    chk_vec("sim29_bx", 32'(dut2.box_x_r), 32'd62);
    chk_vec("sim29_col", 32'(dut2.color_idx_r), 32'd0);
    frame_edge();
    chk_vec("sim_bx", 32'(dut2.box_x_r), 32'd64);
    chk_vec("sim_by", 32'(dut2.box_y_r), 32'd64);
    chk_vec("sim_dx", 32'(dut2.dx_r), 32'd0);
    chk_vec("sim_dy", 32'(dut2.dy_r), 32'd0);
    chk_vec("sim_col", 32'(dut2.color_idx_r), 32'd1);
    x = 10'd70; y = 10'd70; active_video = 1'b1;
    cyc();
    chk_vec("sim_rgb", 32'({red2, green2, blue2}), 32'h0F0);
    active_video = 1'b0;
    frame_edge();
    chk_vec("sim_after_bx", 32'(dut2.box_x_r), 32'd62);
    chk_vec("sim_after_col", 32'(dut2.color_idx_r), 32'd1);

    // Mid-line asynchronous reset.
    x = 10'd100; y = 10'd100; active_video = 1'b1; hsync_in = 1'b0;
    cyc();
    chk_vec("pre_rst_rgb", rgb1(), 32'h004);
    chk_vec("pre_rst_hs", 32'(hsync_out), 32'd0);
    #5 rst_n = 1'b0;
    #1;
    chk_vec("mid_rst_rgb", rgb1(), 32'h000);
    chk_vec("mid_rst_hs", 32'(hsync_out), 32'd1);
    chk_vec("mid_rst_tick", 32'(frame_tick), 32'd0);
    chk_box("mid_rst", 4, 4, 1, 1, 0);
    active_video = 1'b0; hsync_in = 1'b1;
    cyc();
    rst_n = 1'b1;
    frame_edge();
    chk_box("post_rst", 6, 6, 1, 1, 0);

    // Sync and blanking alignment under arbitrary input patterns.
    for (int i = 0; i < 32; i++) begin
      hs_v = 1'($urandom_range(0, 1));
      vs_v = 1'($urandom_range(0, 1));
      av_v = 1'($urandom_range(0, 1));
      hsync_in = hs_v; vsync_in = vs_v; active_video = av_v;
      x = 10'($urandom_range(0, 639));
      y = 10'($urandom_range(0, 479));
      chk_vec("hs_hold", 32'(hsync_out), 32'(hsync_out2));
      cyc();
      chk_vec("hs_dly", 32'(hsync_out), 32'(hs_v));
      chk_vec("vs_dly", 32'(vsync_out), 32'(vs_v));
      chk_vec("vs2_dly", 32'(vsync_out2), 32'(vs_v));
      if (!av_v) chk_vec("av_blank", rgb1(), 32'h000);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
